// File: rtl/round_key_gen_if.sv
// Round-key handshake bundle between the key schedule and its AddRoundKey consumer.
interface round_key_gen_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned IDX_W = 4;

  logic             start_i;
  logic [KEY_W-1:0] key_i;
  logic             flush_i;
  logic             rk_ready_i;
  logic             rk_valid_o;
  logic [KEY_W-1:0] round_key_o;
  logic [IDX_W-1:0] round_idx_o;
  logic             busy_o;
  logic             done_o;

  // Controller / consumer side
  modport master (
    output start_i, key_i, flush_i, rk_ready_i,
    input  rk_valid_o, round_key_o, round_idx_o, busy_o, done_o
  );

  // Key-schedule side
  modport slave (
    input  start_i, key_i, flush_i, rk_ready_i,
    output rk_valid_o, round_key_o, round_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/round_key_gen.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one per accepted handshake.

// AES forward S-box, purely combinational.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s_c
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup
  assign s_c = SBOX[a];
endmodule

module round_key_gen #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  round_key_gen_if.slave bus
);
  localparam int unsigned IDX_W = 4;

  // Only the AES-128 schedule is implemented
  if (NR != 10 || KEY_W != 128) begin : g_param_err
    $error("round_key_gen: only NR=10, KEY_W=128 is supported");
  end

  typedef enum logic {IDLE, OUT} state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [31:0]      w0, w1, w2, w3, rot_w, sub_w, t_w;
  logic [31:0]      n0, n1, n2, n3;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       rcon;
  logic             xfer;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // RotWord: {b1,b2,b3,b0}
  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord, one S-box per byte lane
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[8*g +: 8]), .s_c(sub_w[8*g +: 8]));
  end

  assign idx_next = idx_q + IDX_W'(1);

  // Round constant selected by the round being produced
  always_comb begin
    rcon = 8'h00;
    case (idx_next)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w = sub_w ^ {rcon, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign xfer = valid_q & bus.rk_ready_i;

  // Next-state and next-output logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          key_d   = bus.key_i;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (xfer) begin
          if (idx_q == IDX_W'(NR)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            key_d = {n0, n1, n2, n3};
            idx_d = idx_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
      key_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rk_valid_o  = valid_q;
  assign bus.round_key_o = key_q;
  assign bus.round_idx_o = idx_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
endmodule

// File: tb/tb_round_key_gen.sv
// Directed bench for round_key_gen using FIPS-197 and zero-key schedules.
module tb_round_key_gen;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [127:0] exp_tab [0:10];
  bit           exp_chk [0:10];

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] JUNK = 128'h00112233445566778899aabbccddeeff;

  round_key_gen_if bus ();

  round_key_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic load_t1();
    exp_tab[0]  = K1;
    exp_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) exp_chk[i] = 1'b1;
  endtask

  task automatic load_zero();
    for (int i = 0; i < 11; i++) begin
      exp_tab[i] = '0;
      exp_chk[i] = 1'b0;
    end
    exp_tab[1]  = 128'h62636363626363636263636362636363;
    exp_tab[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_chk[0]  = 1'b1;
    exp_chk[1]  = 1'b1;
    exp_chk[10] = 1'b1;
  endtask

  // Pulse start with a key; returns at the negedge after acceptance
  task automatic do_start(input logic [127:0] key);
    bus.start_i = 1'b1;
    bus.key_i   = key;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.key_i   = JUNK;
    check("start_valid", 128'(bus.rk_valid_o), 128'(1));
    check("start_idx",   128'(bus.round_idx_o), 128'(0));
    check("start_busy",  128'(bus.busy_o), 128'(1));
  endtask

  // Drain a whole schedule; optional random ready and a stray start at idx inject
  task automatic run_keys(input bit rnd, input int inject);
    int           xfers = 0;
    int           dones = 0;
    int           cyc   = 0;
    bit           hold  = 1'b0;
    logic [127:0] pk    = '0;
    logic [3:0]   pi    = '0;
    while (xfers < 11 && cyc < 400) begin
      if (hold) begin
        check("hold_key", bus.round_key_o, pk);
        check("hold_idx", 128'(bus.round_idx_o), 128'(pi));
      end
      check("valid_high", 128'(bus.rk_valid_o), 128'(1));
      bus.rk_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.start_i    = (int'(bus.round_idx_o) == inject);
      bus.key_i      = JUNK;
      if (bus.rk_valid_o && bus.rk_ready_i) begin
        check("xfer_idx", 128'(bus.round_idx_o), 128'(xfers));
        if (exp_chk[xfers]) check("xfer_key", bus.round_key_o, exp_tab[xfers]);
        xfers++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        pk   = bus.round_key_o;
        pi   = bus.round_idx_o;
      end
      if (bus.done_o) dones++;
      @(negedge clk);
      cyc++;
    end
    bus.rk_ready_i = 1'b0;
    bus.start_i    = 1'b0;
    check("xfer_count", 128'(xfers), 128'(11));
    check("early_done", 128'(dones), 128'(0));
    check("done_pulse", 128'(bus.done_o), 128'(1));
    check("end_valid",  128'(bus.rk_valid_o), 128'(0));
    check("end_busy",   128'(bus.busy_o), 128'(0));
    check("end_idx",    128'(bus.round_idx_o), 128'(10));
    @(negedge clk);
    check("done_once",  128'(bus.done_o), 128'(0));
    check("idle_valid", 128'(bus.rk_valid_o), 128'(0));
  endtask

  task automatic wait_idx(input int target);
    int cyc = 0;
    while (int'(bus.round_idx_o) != target && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx", 128'(bus.round_idx_o), 128'(target));
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.key_i      = '0;
    bus.flush_i    = 1'b0;
    bus.rk_ready_i = 1'b0;
    @(negedge clk);
    check("rst_valid", 128'(bus.rk_valid_o), 128'(0));
    check("rst_key",   bus.round_key_o, 128'(0));
    check("rst_idx",   128'(bus.round_idx_o), 128'(0));
    check("rst_busy",  128'(bus.busy_o), 128'(0));
    check("rst_done",  128'(bus.done_o), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // T1: FIPS-197 key, ready held high
    load_t1();
    do_start(K1);
    run_keys(1'b0, -1);

    // T3: random back-pressure
    do_start(K1);
    run_keys(1'b1, -1);

    // T4: stray start with another key at idx 4
    do_start(K1);
    run_keys(1'b0, 4);

    // T5: flush at idx 6 with ready and start asserted
    do_start(K1);
    bus.rk_ready_i = 1'b1;
    wait_idx(6);
    bus.flush_i = 1'b1;
    bus.start_i = 1'b1;
    bus.key_i   = JUNK;
    @(negedge clk);
    bus.flush_i    = 1'b0;
    bus.start_i    = 1'b0;
    bus.rk_ready_i = 1'b0;
    check("flush_valid", 128'(bus.rk_valid_o), 128'(0));
    check("flush_busy",  128'(bus.busy_o), 128'(0));
    check("flush_idx",   128'(bus.round_idx_o), 128'(0));
    check("flush_key",   bus.round_key_o, 128'(0));
    check("flush_done",  128'(bus.done_o), 128'(0));
    @(negedge clk);
    check("flush_nodone", 128'(bus.done_o), 128'(0));
    do_start(K1);
    check("restart_key", bus.round_key_o, K1);
    run_keys(1'b0, -1);

    // T6: asynchronous reset at idx 3
    do_start(K1);
    bus.rk_ready_i = 1'b1;
    wait_idx(3);
    bus.rk_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(bus.rk_valid_o), 128'(0));
    check("arst_key",   bus.round_key_o, 128'(0));
    check("arst_idx",   128'(bus.round_idx_o), 128'(0));
    check("arst_busy",  128'(bus.busy_o), 128'(0));
    check("arst_done",  128'(bus.done_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 128'(bus.rk_valid_o), 128'(0));
      check("post_rst_busy",  128'(bus.busy_o), 128'(0));
    end

    // T2: all-zero key
    load_zero();
    do_start('0);
    run_keys(1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
